volume_history_writer: RTL and testbench

- Producer side of the OLED volume bar graph. Samples the 12-bit microphone stream and computes a peak amplitude per window.
- Quantises each peak to a 0..16 bar level and maintains a 16-column scrolling history.
- The renderer reads the history by column index and draws column c as a bar of rd_level cells (rows 0..rd_level-1 lit).

---
 rtl/volume_history_writer.sv | 105 ++++++++++
 tb/tb_volume_history_writer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/volume_history_writer.sv
// Producer side of the OLED volume bar graph: per-window peak detection of the mic
// stream, 0..16 quantisation and a 16-column scrolling history with registered readout.
module volume_history_writer #(
    parameter int SAMPLE_DIV = 5000,
    parameter int WINDOW     = 4000,
    parameter int NUM_COLS   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] mic_in,
    input  logic        hold,
    input  logic [3:0]  rd_col,
    output logic [4:0]  rd_level,
    output logic        commit,
    output logic [4:0]  cur_level
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      peak_q, peak_d;
    logic [4:0]       hist_q [NUM_COLS];
    logic [4:0]       hist_d [NUM_COLS];
    logic [4:0]       rd_level_q;
    logic             commit_q, commit_d;
    logic [4:0]       cur_level_q, cur_level_d;

    logic             sample_tick;
    logic             win_end;
    logic [10:0]      amp;
    logic [10:0]      peak_new;
    logic [4:0]       level;

    // The largest 11-bit peak maps to exactly 16, so no explicit clamp is needed.
    function automatic logic [4:0] quantise(input logic [10:0] p);
        if (p == 11'd0) begin
            return 5'd0;
        end
        return {1'b0, p[10:7]} + 5'd1;
    endfunction

    always_comb begin
        sample_tick = (div_q == DIV_LAST);
        win_end     = sample_tick && (cnt_q == CNT_LAST);
        amp         = mic_in[11] ? mic_in[10:0] : 11'd0;
        peak_new    = (amp > peak_q) ? amp : peak_q;
        level       = quantise(peak_new);

        div_d = sample_tick ? '0 : div_q + DIV_W'(1);

        cnt_d  = cnt_q;
        peak_d = peak_q;
        if (sample_tick) begin
            cnt_d  = win_end ? '0 : cnt_q + CNT_W'(1);
            peak_d = win_end ? 11'd0 : peak_new;
        end

        commit_d    = win_end && !hold;
        cur_level_d = cur_level_q;
        for (int i = 0; i < NUM_COLS; i++) begin
            hist_d[i] = hist_q[i];
        end
        // Oldest column falls off index 0; the fresh level enters at the newest slot.
        if (commit_d) begin
            for (int i = 0; i < NUM_COLS - 1; i++) begin
                hist_d[i] = hist_q[i + 1];
            end
            hist_d[NUM_COLS - 1] = level;
            cur_level_d          = level;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            cnt_q       <= '0;
            peak_q      <= 11'd0;
            rd_level_q  <= 5'd0;
            commit_q    <= 1'b0;
            cur_level_q <= 5'd0;
            for (int i = 0; i < NUM_COLS; i++) begin
                hist_q[i] <= 5'd0;
            end
        end else begin
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            peak_q      <= peak_d;
            rd_level_q  <= hist_q[rd_col];
            commit_q    <= commit_d;
            cur_level_q <= cur_level_d;
            for (int i = 0; i < NUM_COLS; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign rd_level  = rd_level_q;
    assign commit    = commit_q;
    assign cur_level = cur_level_q;

endmodule

// File: tb/tb_volume_history_writer.sv
// Bench for volume_history_writer: directed window table, randomized windows,
// hold and mid-window reset, all checked against a window-level reference model.
module tb_volume_history_writer;

    localparam int SD = 4;
    localparam int WN = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] mic_in;
    logic        hold;
    logic [3:0]  rd_col;
    logic [4:0]  rd_level;
    logic        commit;
    logic [4:0]  cur_level;

    volume_history_writer #(.SAMPLE_DIV(SD), .WINDOW(WN), .NUM_COLS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .mic_in    (mic_in),
        .hold      (hold),
        .rd_col    (rd_col),
        .rd_level  (rd_level),
        .commit    (commit),
        .cur_level (cur_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int commits_seen    = 0;
    int last_commit_cyc = -1;

    // reference model state
    logic [4:0]  exp_hist [16];
    logic [4:0]  exp_cur;
    int          exp_commits = 0;
    int          rel_cyc = 0;
    int          win_idx = 0;
    logic [3:0]  sweep = 4'd0;
    logic [11:0] win_s [WN];

    typedef struct {
        logic [11:0] fill;
        int          pos;
        logic [11:0] val;
        logic [4:0]  exp;
    } vec_t;
    vec_t tbl [12];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (commit === 1'b1) begin
            commits_seen++;
            last_commit_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int amp_of(input int m);
        return (m >= 2048) ? m - 2048 : 0;
    endfunction

    function automatic int model_level(input int peak);
        int l;
        if (peak == 0) return 0;
        l = peak / 128 + 1;
        return (l > 16) ? 16 : l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One mic sample slot (SD cycles); a history column is read back every cycle.
    task automatic drive_sample(input logic [11:0] v);
        logic [4:0] exp_rd;
        mic_in = v;
        for (int k = 0; k < SD; k++) begin
            rd_col = sweep;
            exp_rd = exp_hist[sweep];
            sweep  = sweep + 4'd1;
            @(posedge clk);
            @(negedge clk);
            check("rd_level", {27'd0, rd_level}, {27'd0, exp_rd});
        end
    endtask

    task automatic run_window(input logic h_early, input logic h_end);
        int peak = 0;
        int lvl;
        for (int i = 0; i < WN; i++) begin
            hold = (i == WN - 1) ? h_end : h_early;
            if (amp_of(int'(win_s[i])) > peak) peak = amp_of(int'(win_s[i]));
            drive_sample(win_s[i]);
        end
        lvl = model_level(peak);
        win_idx++;
        check("commit_pulse", {31'd0, commit}, {31'd0, !h_end});
        if (!h_end) begin
            for (int i = 0; i < 15; i++) exp_hist[i] = exp_hist[i + 1];
            exp_hist[15] = 5'(lvl);
            exp_cur      = 5'(lvl);
            exp_commits++;
            check("commit_cycle", last_commit_cyc, rel_cyc + SD * WN * win_idx);
        end
        check("cur_level", {27'd0, cur_level}, {27'd0, exp_cur});
        check("commit_count", commits_seen, exp_commits);
        hold = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        hold   = 1'b0;
        mic_in = 12'd2048;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        rel_cyc = cyc;
        win_idx = 0;
        for (int i = 0; i < 16; i++) exp_hist[i] = 5'd0;
        exp_cur = 5'd0;
        check("rst_rd_level", {27'd0, rd_level}, 32'd0);
        check("rst_commit", {31'd0, commit}, 32'd0);
        check("rst_cur_level", {27'd0, cur_level}, 32'd0);
    endtask

    initial begin
        int base;
        reset  = 1'b1;
        hold   = 1'b0;
        mic_in = 12'd2048;
        rd_col = 4'd0;
        for (int i = 0; i < 16; i++) exp_hist[i] = 5'd0;
        exp_cur = 5'd0;

        tbl[0]  = '{12'd2048, 3, 12'd3000, 5'd8};
        tbl[1]  = '{12'd2048, 0, 12'd4095, 5'd16};
        tbl[2]  = '{12'd2048, 5, 12'd2176, 5'd2};
        tbl[3]  = '{12'd2048, 2, 12'd2049, 5'd1};
        tbl[4]  = '{12'd0,    4, 12'd0,    5'd0};
        tbl[5]  = '{12'd2048, 7, 12'd2300, 5'd2};
        tbl[6]  = '{12'd2048, 0, 12'd2048, 5'd0};
        tbl[7]  = '{12'd2048, 6, 12'd2175, 5'd1};
        tbl[8]  = '{12'd1000, 1, 12'd2176, 5'd2};
        tbl[9]  = '{12'd2048, 7, 12'd3968, 5'd16};
        tbl[10] = '{12'd2048, 4, 12'd3071, 5'd8};
        tbl[11] = '{12'd2049, 2, 12'd3967, 5'd15};

        @(negedge clk);
        do_reset();

        // silence: three windows of level 0, commits 32 cycles apart
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < WN; i++) win_s[i] = 12'd2048;
            run_window(1'b0, 1'b0);
        end

        // directed single-peak windows, including the final-sample case
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < WN; i++) win_s[i] = tbl[t].fill;
            win_s[tbl[t].pos] = tbl[t].val;
            run_window(1'b0, 1'b0);
            check("tbl_level", {27'd0, cur_level}, {27'd0, tbl[t].exp});
        end

        // 17 windows with levels 0..16 push the first one out of the history
        for (int l = 0; l <= 16; l++) begin
            base = (l == 0) ? 2048 : 2048 + (l - 1) * 128;
            for (int i = 0; i < WN; i++) win_s[i] = 12'($urandom_range(0, base));
            if (l != 0) win_s[$urandom_range(0, WN - 1)] = 12'(base + $urandom_range(0, 127));
            run_window(1'b0, 1'b0);
        end

        // random windows with random hold
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < WN; i++) win_s[i] = 12'($urandom_range(0, 4095));
            run_window(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        // hold across two window ends, then hold dropped just before a window end
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < WN; i++) win_s[i] = 12'($urandom_range(2048, 4095));
            run_window(1'b1, 1'b1);
        end
        for (int i = 0; i < WN; i++) win_s[i] = 12'($urandom_range(2048, 4095));
        run_window(1'b1, 1'b0);

        // reset in the middle of a loud window; the partial peak must be discarded
        for (int i = 0; i < 3; i++) drive_sample(12'd4095);
        do_reset();
        for (int i = 0; i < WN; i++) win_s[i] = 12'd2048;
        run_window(1'b0, 1'b0);
        for (int i = 0; i < WN; i++) win_s[i] = 12'($urandom_range(0, 4095));
        run_window(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
